// File: rtl/i3c_frame_rx.sv
// Framed packet receiver: hunts header/payload/XOR-check frames and buffers payload speculatively.
// Optional idle timeout inside a frame is enabled by defining I3C_FRAME_TIMEOUT_EN.
module i3c_frame_rx #(
    parameter int          DEPTH_LOG2     = 3,
    parameter logic [7:0]  SYNC           = 8'hA5,
    parameter int          TIMEOUT_CYCLES = 64
) (
    input  logic        bus_clk,
    input  logic        rst,
    input  logic [15:0] word_in,
    input  logic        word_valid,
    output logic [15:0] tx_word,
    output logic [15:0] pl_data,
    output logic        pl_last,
    output logic        pl_valid,
    input  logic        pl_ready,
    output logic        frame_ok,
    output logic        frame_err,
    output logic [7:0]  err_count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;

    localparam logic [1:0] S_HUNT    = 2'd0;
    localparam logic [1:0] S_PAYLOAD = 2'd1;
    localparam logic [1:0] S_CHECK   = 2'd2;
    localparam logic [1:0] S_DROP    = 2'd3;

    logic [1:0]    state, state_n;
    logic [4:0]    remaining, remaining_n;
    logic [15:0]   csum, csum_n;
    logic [PW-1:0] rd_ptr, rd_ptr_n;
    logic [PW-1:0] wr_spec, wr_spec_n;
    logic [PW-1:0] wr_com, wr_com_n;
    logic [1:0]    status, status_n;
    logic          ok_n, err_n, wr_en, pop, timeout;
    logic [PW-1:0] level, free, level_n;
    logic [31:0]   level_wide;
    logic [3:0]    level_sat;
    logic [16:0]   mem [DEPTH];

`ifdef I3C_FRAME_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
    logic [IW-1:0] idle_cnt;

    always_ff @(posedge bus_clk or posedge rst) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if (word_valid || state == S_HUNT || timeout) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    assign timeout = (state != S_HUNT) && !word_valid && (idle_cnt == IW'(TIMEOUT_CYCLES));
`else
    assign timeout = 1'b0;
`endif

    assign pl_valid = (rd_ptr != wr_com);
    assign pl_data  = mem[rd_ptr[DEPTH_LOG2-1:0]][15:0];
    assign pl_last  = mem[rd_ptr[DEPTH_LOG2-1:0]][16];
    assign pop      = pl_valid && pl_ready;
    // Free space counts only committed words; the speculative region always fits inside it.
    assign level    = wr_com - rd_ptr;
    assign free     = PW'(DEPTH) - level;

    always_comb begin
        state_n     = state;
        remaining_n = remaining;
        csum_n      = csum;
        wr_spec_n   = wr_spec;
        wr_com_n    = wr_com;
        status_n    = status;
        ok_n        = 1'b0;
        err_n       = 1'b0;
        wr_en       = 1'b0;
        if (word_valid) begin
            case (state)
                S_HUNT: begin
                    if (word_in[15:8] == SYNC) begin
                        csum_n = word_in;
                        if (word_in[3:0] == 4'd0) begin
                            err_n    = 1'b1;
                            status_n = 2'b11;
                        end else if (32'(word_in[3:0]) > 32'(free)) begin
                            err_n       = 1'b1;
                            status_n    = 2'b11;
                            remaining_n = {1'b0, word_in[3:0]} + 5'd1;
                            state_n     = S_DROP;
                        end else begin
                            remaining_n = {1'b0, word_in[3:0]};
                            state_n     = S_PAYLOAD;
                        end
                    end
                end
                S_PAYLOAD: begin
                    wr_en       = 1'b1;
                    wr_spec_n   = wr_spec + 1'b1;
                    csum_n      = csum ^ word_in;
                    remaining_n = remaining - 5'd1;
                    if (remaining == 5'd1) state_n = S_CHECK;
                end
                S_CHECK: begin
                    if (word_in == csum) begin
                        wr_com_n = wr_spec;
                        ok_n     = 1'b1;
                        status_n = 2'b01;
                    end else begin
                        wr_spec_n = wr_com;
                        err_n     = 1'b1;
                        status_n  = 2'b10;
                    end
                    state_n = S_HUNT;
                end
                default: begin
                    remaining_n = remaining - 5'd1;
                    if (remaining == 5'd1) state_n = S_HUNT;
                end
            endcase
        end
        if (timeout) begin
            wr_spec_n = wr_com;
            err_n     = 1'b1;
            status_n  = 2'b11;
            state_n   = S_HUNT;
        end
    end

    // tx_word reflects the post-edge status and level so it moves with frame_ok/frame_err.
    always_comb begin
        rd_ptr_n   = rd_ptr + PW'(pop);
        level_n    = wr_com_n - rd_ptr_n;
        level_wide = 32'(level_n);
        level_sat  = (level_wide > 32'd15) ? 4'hF : level_wide[3:0];
    end

    always_ff @(posedge bus_clk or posedge rst) begin
        if (rst) begin
            state     <= S_HUNT;
            remaining <= '0;
            csum      <= '0;
            rd_ptr    <= '0;
            wr_spec   <= '0;
            wr_com    <= '0;
            status    <= 2'b00;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            err_count <= 8'd0;
            tx_word   <= 16'h5A00;
        end else begin
            state     <= state_n;
            remaining <= remaining_n;
            csum      <= csum_n;
            rd_ptr    <= rd_ptr_n;
            wr_spec   <= wr_spec_n;
            wr_com    <= wr_com_n;
            status    <= status_n;
            frame_ok  <= ok_n;
            frame_err <= err_n;
            if (err_n && err_count != 8'hFF) err_count <= err_count + 8'd1;
            tx_word   <= {8'h5A, 2'b00, status_n, level_sat};
        end
    end

    always_ff @(posedge bus_clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[wr_spec[DEPTH_LOG2-1:0]] <= {remaining == 5'd1, word_in};
        end
    end

endmodule

// File: tb/tb_i3c_frame_rx.sv
// Self-checking bench for i3c_frame_rx: directed scenarios plus randomized frame streams
// compared against a frame-level reference model.
module tb_i3c_frame_rx;

  logic        bus_clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] word_in = '0;
  logic        word_valid = 1'b0;
  logic [15:0] tx_word;
  logic [15:0] pl_data;
  logic        pl_last;
  logic        pl_valid;
  logic        pl_ready = 1'b0;
  logic        frame_ok;
  logic        frame_err;
  logic [7:0]  err_count;

  int n_checks = 0;
  int n_pass = 0;

  i3c_frame_rx dut (
    .bus_clk(bus_clk), .rst(rst), .word_in(word_in), .word_valid(word_valid),
    .tx_word(tx_word), .pl_data(pl_data), .pl_last(pl_last), .pl_valid(pl_valid),
    .pl_ready(pl_ready), .frame_ok(frame_ok), .frame_err(frame_err), .err_count(err_count)
  );

  always #5 bus_clk = ~bus_clk;

  // Reference model: frame-level parser with a committed-payload queue.
  localparam int M_HUNT = 0, M_COLLECT = 1, M_CHECK = 2, M_DROP = 3;
  logic [16:0] exp_q[$];
  logic [16:0] pend_q[$];
  int          m_mode, m_left, m_errs;
  logic [15:0] m_csum;
  logic [1:0]  m_status;
  logic        exp_ok, exp_err;

  function automatic void model_reset();
    exp_q.delete();
    pend_q.delete();
    m_mode = M_HUNT; m_left = 0; m_errs = 0;
    m_csum = '0; m_status = 2'b00; exp_ok = 0; exp_err = 0;
  endfunction

  function automatic logic [15:0] model_tx();
    int lvl;
    lvl = (exp_q.size() > 15) ? 15 : exp_q.size();
    return {8'h5A, 2'b00, m_status, 4'(lvl)};
  endfunction

  task automatic model_step(input logic v, input logic [15:0] w, input logic rdy);
    int size_pre;
    logic pop_now;
    size_pre = exp_q.size();
    pop_now  = rdy && (size_pre != 0);
    exp_ok = 0;
    exp_err = 0;
    if (v) begin
      case (m_mode)
        M_HUNT: if (w[15:8] == 8'hA5) begin
          if (w[3:0] == 4'd0) begin
            exp_err = 1; m_status = 2'b11;
          end else if (int'(w[3:0]) > 8 - size_pre) begin
            exp_err = 1; m_status = 2'b11; m_left = int'(w[3:0]) + 1; m_mode = M_DROP;
          end else begin
            m_left = int'(w[3:0]); m_csum = w; pend_q.delete(); m_mode = M_COLLECT;
          end
        end
        M_COLLECT: begin
          pend_q.push_back({m_left == 1, w});
          m_csum = m_csum ^ w;
          m_left--;
          if (m_left == 0) m_mode = M_CHECK;
        end
        M_CHECK: begin
          if (w == m_csum) begin
            foreach (pend_q[i]) exp_q.push_back(pend_q[i]);
            exp_ok = 1; m_status = 2'b01;
          end else begin
            exp_err = 1; m_status = 2'b10;
          end
          pend_q.delete();
          m_mode = M_HUNT;
        end
        default: begin
          m_left--;
          if (m_left == 0) m_mode = M_HUNT;
        end
      endcase
    end
    if (exp_err && m_errs < 255) m_errs++;
    if (pop_now) void'(exp_q.pop_front());
  endtask

  // One clock cycle, entered and left at a falling edge; scoreboards the head and the outputs.
  task automatic cycle(input logic v, input logic [15:0] w, input logic rdy);
    logic [15:0] exp_tx;
    n_checks++;
    if (pl_valid !== (exp_q.size() != 0))
      $display("FAIL pl_valid_pre: got %0b expected %0b", pl_valid, exp_q.size() != 0);
    else n_pass++;
    if (exp_q.size() != 0) begin
      n_checks++;
      if ({pl_last, pl_data} !== exp_q[0])
        $display("FAIL head: got last=%0b data=%h expected %h", pl_last, pl_data, exp_q[0]);
      else n_pass++;
    end
    word_valid = v; word_in = w; pl_ready = rdy;
    model_step(v, w, rdy);
    exp_tx = model_tx();
    @(posedge bus_clk);
    @(negedge bus_clk);
    word_valid = 1'b0; pl_ready = 1'b0;
    n_checks++;
    if (frame_ok !== exp_ok || frame_err !== exp_err)
      $display("FAIL pulses: got ok=%0b err=%0b expected ok=%0b err=%0b", frame_ok, frame_err, exp_ok, exp_err);
    else n_pass++;
    n_checks++;
    if (err_count !== 8'(m_errs))
      $display("FAIL err_count: got %0d expected %0d", err_count, m_errs);
    else n_pass++;
    n_checks++;
    if (tx_word !== exp_tx)
      $display("FAIL tx_word: got %h expected %h", tx_word, exp_tx);
    else n_pass++;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    word_valid = 1'b0; pl_ready = 1'b0; word_in = '0;
    model_reset();
    repeat (2) @(negedge bus_clk);
    rst = 1'b0;
  endtask

  task automatic send_frame(input int len, input logic corrupt, input logic rdy_rand);
    logic [15:0] w, c;
    w = {8'hA5, 4'h0, 4'(len)};
    c = w;
    cycle(1'b1, w, rdy_rand ? 1'($urandom_range(0, 1)) : 1'b0);
    for (int i = 0; i < len; i++) begin
      w = 16'($urandom);
      c = c ^ w;
      cycle(1'b1, w, rdy_rand ? 1'($urandom_range(0, 1)) : 1'b0);
    end
    if (corrupt) c = c ^ (16'd1 << $urandom_range(0, 15));
    cycle(1'b1, c, rdy_rand ? 1'($urandom_range(0, 1)) : 1'b0);
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if (tx_word !== 16'h5A00 || pl_valid !== 1'b0 || frame_ok !== 1'b0 || frame_err !== 1'b0 ||
        err_count !== 8'd0 || pl_data !== 16'h0000 || pl_last !== 1'b0)
      $display("FAIL reset_values: got tx=%h v=%0b ok=%0b err=%0b cnt=%0d data=%h last=%0b expected 5a00 and zeros",
               tx_word, pl_valid, frame_ok, frame_err, err_count, pl_data, pl_last);
    else n_pass++;
  endtask

  task automatic test_good_frame();
    apply_reset();
    cycle(1'b1, 16'hA502, 1'b0);
    cycle(1'b1, 16'h1234, 1'b0);
    cycle(1'b1, 16'hABCD, 1'b0);
    n_checks++;
    if (pl_valid !== 1'b0) $display("FAIL uncommitted_visible: got %0b expected 0", pl_valid);
    else n_pass++;
    cycle(1'b1, 16'h1CFB, 1'b0);
    n_checks++;
    if (frame_ok !== 1'b1 || tx_word !== 16'h5A12 || pl_valid !== 1'b1)
      $display("FAIL good_commit: got ok=%0b tx=%h v=%0b expected 1 5a12 1", frame_ok, tx_word, pl_valid);
    else n_pass++;
    n_checks++;
    if (pl_data !== 16'h1234 || pl_last !== 1'b0)
      $display("FAIL good_head0: got %h/%0b expected 1234/0", pl_data, pl_last);
    else n_pass++;
    cycle(1'b0, 16'h0000, 1'b1);
    n_checks++;
    if (pl_data !== 16'hABCD || pl_last !== 1'b1)
      $display("FAIL good_head1: got %h/%0b expected abcd/1", pl_data, pl_last);
    else n_pass++;
    cycle(1'b0, 16'h0000, 1'b1);
    n_checks++;
    if (tx_word !== 16'h5A10 || pl_valid !== 1'b0)
      $display("FAIL good_drained: got tx=%h v=%0b expected 5a10 0", tx_word, pl_valid);
    else n_pass++;
  endtask

  task automatic test_bad_check();
    apply_reset();
    cycle(1'b1, 16'hA502, 1'b0);
    cycle(1'b1, 16'h1111, 1'b0);
    cycle(1'b1, 16'h2222, 1'b0);
    cycle(1'b1, 16'h0000, 1'b0);
    n_checks++;
    if (frame_err !== 1'b1 || pl_valid !== 1'b0 || err_count !== 8'd1 || tx_word !== 16'h5A20)
      $display("FAIL bad_check: got err=%0b v=%0b cnt=%0d tx=%h expected 1 0 1 5a20",
               frame_err, pl_valid, err_count, tx_word);
    else n_pass++;
  endtask

  task automatic test_overflow();
    apply_reset();
    send_frame(4, 1'b0, 1'b0);
    send_frame(4, 1'b0, 1'b0);
    cycle(1'b1, 16'hA501, 1'b0);
    n_checks++;
    if (frame_err !== 1'b1 || tx_word !== 16'h5A38)
      $display("FAIL overflow_reject: got err=%0b tx=%h expected 1 5a38", frame_err, tx_word);
    else n_pass++;
    cycle(1'b1, 16'hA501, 1'b0);
    cycle(1'b1, 16'h0055, 1'b0);
    cycle(1'b0, 16'h0000, 1'b1);
    cycle(1'b1, 16'hA501, 1'b0);
    cycle(1'b1, 16'h0055, 1'b0);
    cycle(1'b1, 16'hA554, 1'b0);
    n_checks++;
    if (frame_ok !== 1'b1 || tx_word !== 16'h5A18)
      $display("FAIL overflow_recover: got ok=%0b tx=%h expected 1 5a18", frame_ok, tx_word);
    else n_pass++;
    while (exp_q.size() != 0) cycle(1'b0, 16'h0000, 1'b1);
  endtask

  task automatic test_garbage();
    apply_reset();
    cycle(1'b1, 16'h0000, 1'b0);
    cycle(1'b1, 16'hFFFF, 1'b0);
    cycle(1'b1, 16'hA501, 1'b0);
    cycle(1'b1, 16'h0007, 1'b0);
    cycle(1'b1, 16'hA506, 1'b0);
    n_checks++;
    if (frame_ok !== 1'b1 || pl_data !== 16'h0007 || pl_last !== 1'b1 || err_count !== 8'd0)
      $display("FAIL garbage_frame: got ok=%0b data=%h last=%0b cnt=%0d expected 1 0007 1 0",
               frame_ok, pl_data, pl_last, err_count);
    else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    apply_reset();
    cycle(1'b1, 16'hA500, 1'b0);
    cycle(1'b1, 16'hA502, 1'b0);
    cycle(1'b1, 16'h1234, 1'b0);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (tx_word !== 16'h5A00 || err_count !== 8'd0 || pl_valid !== 1'b0 ||
        frame_ok !== 1'b0 || frame_err !== 1'b0)
      $display("FAIL async_reset: got tx=%h cnt=%0d v=%0b ok=%0b err=%0b expected 5a00 0 0 0 0",
               tx_word, err_count, pl_valid, frame_ok, frame_err);
    else n_pass++;
    model_reset();
    @(negedge bus_clk);
    rst = 1'b0;
    cycle(1'b1, 16'hA502, 1'b0);
    cycle(1'b1, 16'h1234, 1'b0);
    cycle(1'b1, 16'hABCD, 1'b0);
    cycle(1'b1, 16'h1CFB, 1'b0);
    n_checks++;
    if (frame_ok !== 1'b1 || tx_word !== 16'h5A12)
      $display("FAIL post_reset_frame: got ok=%0b tx=%h expected 1 5a12", frame_ok, tx_word);
    else n_pass++;
  endtask

  task automatic test_random_stream();
    int kind;
    logic [15:0] g;
    apply_reset();
    for (int f = 0; f < 150; f++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        g = 16'($urandom);
        if (g[15:8] == 8'hA5) g[15:8] = 8'h00;
        cycle(1'b1, g, 1'($urandom_range(0, 1)));
      end else if (kind == 1) begin
        cycle(1'b1, 16'hA500 | 16'($urandom_range(0, 255) & 16'h00F0), 1'($urandom_range(0, 1)));
      end else begin
        send_frame($urandom_range(1, 9), kind == 2, 1'b1);
      end
      repeat ($urandom_range(0, 2)) cycle(1'b0, 16'h0000, 1'($urandom_range(0, 1)));
    end
    while (exp_q.size() != 0) cycle(1'b0, 16'h0000, 1'b1);
  endtask

  task automatic test_err_saturation();
    apply_reset();
    for (int i = 0; i < 260; i++) cycle(1'b1, 16'hA500, 1'b0);
    n_checks++;
    if (err_count !== 8'd255 || tx_word !== 16'h5A30)
      $display("FAIL err_saturate: got cnt=%0d tx=%h expected 255 5a30", err_count, tx_word);
    else n_pass++;
  endtask

  initial begin
    @(negedge bus_clk);
    test_reset();
    test_good_frame();
    test_bad_check();
    test_overflow();
    test_garbage();
    test_reset_mid_frame();
    test_random_stream();
    test_err_saturation();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
